// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control unit and bus front-end for the
// 8-register processor (mv, mvi, add, sub over timesteps T0-T3).
// Optional build macro OP_AND_EN turns opcode 100 into "and Rx,Ry";
// without it opcode 100 is treated as illegal and no AND logic exists.
module unidade_controle #(
  parameter int DATA_W = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [DATA_W-1:0]     din,
  input  logic [8*DATA_W-1:0]   regs_flat,
  output logic [DATA_W-1:0]     buswire,
  output logic [7:0]            r_wren,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
`ifdef OP_AND_EN
  localparam logic [2:0] OP_AND = 3'b100;
`endif

  state_t            state;
  logic [2:0]        ir_op;
  logic [2:0]        ir_x;
  logic [2:0]        ir_y;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] regs [8];
  logic [1:0]        rst_sync;
  logic              rst_n;

  logic [2:0] din_op;
  logic [2:0] din_x;

  assign din_op = din[DATA_W-1 -: 3];
  assign din_x  = din[DATA_W-4 -: 3];

  // Instructions that go through A and G and take T1..T3
  function automatic logic is_long(input logic [2:0] op);
`ifdef OP_AND_EN
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`else
    return (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

  // Single-cycle instructions that write a register in T1
  function automatic logic is_move(input logic [2:0] op);
    return (op == OP_MV) || (op == OP_MVI);
  endfunction

  function automatic logic [7:0] one_hot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

  // Reset asserts immediately but is released only after two clock edges
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Split the flat register readback into an indexable array
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs[i] = regs_flat[i*DATA_W +: DATA_W];
    end
  end

  // Bus source select: decoded from the settled state and IR only
  always_comb begin
    buswire = '0;
    case (state)
      T0: buswire = '0;
      T1: begin
        if (ir_op == OP_MV) begin
          buswire = regs[ir_y];
        end else if (ir_op == OP_MVI) begin
          buswire = din;
        end else if (is_long(ir_op)) begin
          buswire = regs[ir_x];
        end
      end
      T2: buswire = regs[ir_y];
      T3: buswire = g_q;
    endcase
  end

  // Arithmetic unit feeding G; carries and borrows fall off the top
  always_comb begin
    alu_res = '0;
    case (ir_op)
      OP_ADD:  alu_res = a_q + buswire;
      OP_SUB:  alu_res = a_q - buswire;
`ifdef OP_AND_EN
      OP_AND:  alu_res = a_q & buswire;
`endif
      default: alu_res = '0;
    endcase
  end

  // Timestep sequencer with registered write-enables, done and busy
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= T0;
      ir_op  <= '0;
      ir_x   <= '0;
      ir_y   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      r_wren <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        T0: begin
          if (run) begin
            ir_op <= din_op;
            ir_x  <= din_x;
            ir_y  <= din[DATA_W-7 -: 3];
            state <= T1;
            busy  <= 1'b1;
            if (is_long(din_op)) begin
              r_wren <= '0;
              done   <= 1'b0;
            end else begin
              r_wren <= is_move(din_op) ? one_hot(din_x) : 8'h00;
              done   <= 1'b1;
            end
          end else begin
            r_wren <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
          end
        end
        T1: begin
          r_wren <= '0;
          done   <= 1'b0;
          if (is_long(ir_op)) begin
            a_q   <= buswire;
            state <= T2;
          end else begin
            state <= T0;
            busy  <= 1'b0;
          end
        end
        T2: begin
          g_q    <= alu_res;
          state  <= T3;
          r_wren <= one_hot(ir_x);
          done   <= 1'b1;
        end
        T3: begin
          state  <= T0;
          r_wren <= '0;
          done   <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Multicycle control and datapath front-end for the 8-register processor. It fetches an instruction word from `din` and sequences the operations mv, mvi, add and sub over timesteps T0–T3. It drives the shared `buswire` and generates one write-enable per general register. It sits directly upstream of the eight `registrador` instances (R0–R7): it feeds their `buswire`/`wren` inputs and reads their `data_out` back through `regs_flat`.

Parameters:
- DATA_W, 16, width of the bus, registers, A, G and `din`.

Ports:
- clock  in  1  system clock; the FSM, IR, A and G update on posedge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  start-instruction request, sampled in T0.
- din  in  DATA_W  instruction word in T0; immediate operand in T1 of mvi.
- regs_flat  in  8*DATA_W  R0–R7 `data_out`, with R0 in bits [DATA_W-1:0].
- buswire  out  DATA_W  shared bus, combinational from state, IR, `regs_flat`, `din` and G.
- r_wren  out  8  one-hot write enable for R0–R7; all zero when no write.
- done  out  1  high for exactly the last cycle of each instruction.
- busy  out  1  high whenever the FSM is not in T0.

Behaviour:
- Reset (`resetn`=0, asynchronous): state=T0, IR=0, A=0, G=0. Outputs `buswire`=0, `r_wren`=0, `done`=0, `busy`=0. Deassertion is synchronised internally (2-flop) before FSM release.
- Instruction fields (IR = `din` captured in T0):
  - opcode = IR[15:13], X = IR[12:10], Y = IR[9:7].
  - IR[6:0] is ignored.
  - Opcodes: 000 mv, 001 mvi, 010 add, 011 sub; 100–111 illegal unless the optional feature applies.
- Registrador timing: registers capture on the negedge of the same cycle `r_wren` is high. `buswire`/`r_wren` must be glitch-settled within the first half-cycle and must never be driven from negedge logic.
- T0: `buswire`=0, `r_wren`=0. If `run`=1 at posedge: IR<=`din`, go to T1; otherwise stay in T0.
- T1:
  - mv: `buswire`=R[Y], `r_wren`[X]=1, `done`=1, go to T0.
  - mvi: `buswire`=`din`, `r_wren`[X]=1, `done`=1, go to T0.
  - add/sub: `buswire`=R[X], A<=`buswire`, go to T2.
  - illegal: `buswire`=0, no writes, `done`=1, go to T0.
- T2: `buswire`=R[Y]. G<=A+`buswire` (add) or A−`buswire` (sub), modulo 2^DATA_W; carry/borrow discarded. Go to T3.
- T3: `buswire`=G, `r_wren`[X]=1, `done`=1, go to T0.
- Latency (`run` sample to `done`): mv/mvi/illegal 1 cycle after fetch; add/sub 3 cycles after fetch.
- X==Y is legal:
  - mv Rx,Rx rewrites the same value.
  - add Rx,Rx doubles Rx.
  - sub Rx,Rx yields 0.
- `run` is ignored outside T0. `run` held high starts the next instruction in the T0 immediately following `done`; there are no bubbles beyond T0.
- Reset mid-instruction aborts immediately and drops `r_wren` asynchronously. Any partial A/G result is lost; registers not yet written keep their values.
- Illegal opcodes never assert any `r_wren` bit.

Optional Feature:
- Macro: OP_AND_EN.
- Defined: opcode 100 is "and Rx,Ry", sequenced exactly like add but with G<=A & `buswire` in T2.
- Undefined: opcode 100 is illegal (1-cycle `done`, no writes). No AND logic is synthesised.

Test Plan:
- Reset check: assert `resetn`=0 for 3 cycles mid-T2 of an add → `r_wren`=0 and `buswire`=0 at once. After release: `busy`=0 and all registers unchanged.
- mvi R2,#0x1234: `din`=0x2800 in T0, `din`=0x1234 in T1 → `r_wren`=0x04, `buswire`=0x1234, `done`=1 in T1; R2 reads 0x1234.
- mv R5,R2: `din`=0x1500 → `r_wren`=0x20 and `buswire`=0x1234 in T1; R5 reads 0x1234.
- add R2,R5 with R2=R5=0x1234: `din`=0x4A80 → T3 `buswire`=0x2468, `r_wren`=0x04; `done` comes 3 cycles after fetch.
- sub R0,R1 with R0=0x0000, R1=0x0001: `din`=0x6080 → R0=0xFFFF (wrap-around). Then sub R3,R3 → R3=0x0000.
- Opcode 100 (`din`=0x8280): with OP_AND_EN and R0=0xFFFF, R5=0x1234 → R0=0x1234. Without OP_AND_EN → 1-cycle `done` and `r_wren` never nonzero. Also `run` held high across back-to-back instructions → no lost or duplicated fetches.
